// File: rtl/ysyx_22050598_axi_arbiter_pkg.sv
// Shared types and AXI constants for the IF/LS AXI arbiter.
// Round-robin arbitration is enabled by defining YSYX_22050598_AXI_ARB_RR_EN.
package ysyx_22050598_axi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AWW  = 3'd3,
    ST_B    = 3'd4
  } arb_state_e;

  localparam int         IDW        = 4;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] ID_IF      = 4'd0;
  localparam logic [3:0] ID_LS      = 4'd1;

  function automatic logic resp_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/ysyx_22050598_axi_arbiter_if.sv
// AXI4 master bus shared by the IF and LS units; master modport faces the arbiter.
interface ysyx_22050598_axi_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
) ();
  import ysyx_22050598_axi_arbiter_pkg::*;

  logic [IDW-1:0]  awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [IDW-1:0]  arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [3:0]      arqos;
  logic            arvalid;
  logic            arready;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/ysyx_22050598_axi_arbiter_arb_sel.sv
// One-hot grant selection {ls, if}; round-robin when YSYX_22050598_AXI_ARB_RR_EN
// is defined, otherwise fixed LS-over-IF priority.
module ysyx_22050598_arb_sel (
`ifdef YSYX_22050598_AXI_ARB_RR_EN
  input  logic       ptr_ls_i,
`endif
  input  logic       if_req_i,
  input  logic       ls_req_i,
  output logic [1:0] grant_o
);

  // Pick one requester; contention is resolved by the pointer or fixed priority.
  always_comb begin
    grant_o = 2'b00;
    if (ls_req_i && if_req_i) begin
`ifdef YSYX_22050598_AXI_ARB_RR_EN
      grant_o = ptr_ls_i ? 2'b10 : 2'b01;
`else
      grant_o = 2'b10;
`endif
    end else if (ls_req_i) begin
      grant_o = 2'b10;
    end else if (if_req_i) begin
      grant_o = 2'b01;
    end else begin
      grant_o = 2'b00;
    end
  end

endmodule

// File: rtl/ysyx_22050598_axi_arbiter.sv
// Shares one AXI4 master port between IF reads and LS reads/writes, one single-beat
// transaction at a time. YSYX_22050598_AXI_ARB_RR_EN selects round-robin arbitration.
module ysyx_22050598_axi_arbiter
  import ysyx_22050598_axi_arbiter_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [AW-1:0]       if_addr,
  input  logic [2:0]          if_size,
  output logic [DW-1:0]       if_rdata,
  output logic                if_done,
  output logic                if_err,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [AW-1:0]       ls_addr,
  input  logic [2:0]          ls_size,
  input  logic [DW-1:0]       ls_wdata,
  input  logic [DW/8-1:0]     ls_wstrb,
  output logic [DW-1:0]       ls_rdata,
  output logic                ls_done,
  output logic                ls_err,
  ysyx_22050598_axi_arbiter_if.master m_axi
);

  arb_state_e      state_q, state_d;
  logic            grant_ls_q, grant_ls_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
  logic            if_done_q, if_done_d;
  logic            ls_done_q, ls_done_d;
  logic            if_err_q, if_err_d;
  logic            ls_err_q, ls_err_d;
  logic [1:0]      grant_s;
  logic            aw_ok_s;
  logic            w_ok_s;
  logic            unused_axi_s;

`ifdef YSYX_22050598_AXI_ARB_RR_EN
  logic            ptr_ls_q, ptr_ls_d;

  ysyx_22050598_arb_sel u_sel (
    .ptr_ls_i (ptr_ls_q),
    .if_req_i (if_req),
    .ls_req_i (ls_req),
    .grant_o  (grant_s)
  );
`else
  ysyx_22050598_arb_sel u_sel (
    .if_req_i (if_req),
    .ls_req_i (ls_req),
    .grant_o  (grant_s)
  );
`endif

  // A write channel counts as finished once its VALID has dropped or is handshaking now.
  assign aw_ok_s = !awvalid_q || m_axi.awready;
  assign w_ok_s  = !wvalid_q  || m_axi.wready;

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    grant_ls_d = grant_ls_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_err_d   = if_err_q;
    ls_err_d   = ls_err_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
`ifdef YSYX_22050598_AXI_ARB_RR_EN
    ptr_ls_d   = ptr_ls_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Requests seen during a done cycle are ignored to avoid a double grant.
        if (!(if_done_q || ls_done_q) && (grant_s != 2'b00)) begin
          grant_ls_d = grant_s[1];
          addr_d     = grant_s[1] ? ls_addr : if_addr;
          size_d     = grant_s[1] ? ls_size : if_size;
          wdata_d    = ls_wdata;
          wstrb_d    = ls_wstrb;
`ifdef YSYX_22050598_AXI_ARB_RR_EN
          ptr_ls_d   = !grant_s[1];
`endif
          if (grant_s[1] && ls_we) begin
            state_d   = ST_AWW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_AR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (m_axi.arready) begin
          state_d   = ST_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (m_axi.rvalid) begin
          state_d  = ST_IDLE;
          rready_d = 1'b0;
          if (grant_ls_q) begin
            ls_rdata_d = m_axi.rdata;
            ls_err_d   = resp_err(m_axi.rresp);
            ls_done_d  = 1'b1;
          end else begin
            if_rdata_d = m_axi.rdata;
            if_err_d   = resp_err(m_axi.rresp);
            if_done_d  = 1'b1;
          end
        end else begin
          state_d = ST_R;
        end
      end
      ST_AWW: begin
        awvalid_d = awvalid_q && !m_axi.awready;
        wvalid_d  = wvalid_q  && !m_axi.wready;
        if (aw_ok_s && w_ok_s) begin
          state_d  = ST_B;
          bready_d = 1'b1;
        end else begin
          state_d = ST_AWW;
        end
      end
      ST_B: begin
        if (m_axi.bvalid) begin
          state_d   = ST_IDLE;
          bready_d  = 1'b0;
          ls_err_d  = resp_err(m_axi.bresp);
          ls_done_d = 1'b1;
        end else begin
          state_d = ST_B;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State, latched request payload and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      grant_ls_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= 3'd0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      ls_err_q   <= 1'b0;
`ifdef YSYX_22050598_AXI_ARB_RR_EN
      ptr_ls_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      grant_ls_q <= grant_ls_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_err_q   <= if_err_d;
      ls_err_q   <= ls_err_d;
`ifdef YSYX_22050598_AXI_ARB_RR_EN
      ptr_ls_q   <= ptr_ls_d;
`endif
    end
  end

  assign if_rdata = if_rdata_q;
  assign if_done  = if_done_q;
  assign if_err   = if_err_q;
  assign ls_rdata = ls_rdata_q;
  assign ls_done  = ls_done_q;
  assign ls_err   = ls_err_q;

  assign m_axi.arid    = grant_ls_q ? ID_LS : ID_IF;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = size_q;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arqos   = 4'd0;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign m_axi.awid    = ID_LS;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = size_q;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  // Every read is single-beat and only one transaction is in flight, so RLAST and IDs carry no information.
  assign unused_axi_s = &{1'b0, m_axi.rlast, m_axi.rid, m_axi.bid};

endmodule

// File: tb/tb_ysyx_22050598_axi_arbiter.sv
// Directed bench for the IF/LS AXI arbiter: bench-side AXI slave plus an expectation queue.
module tb_ysyx_22050598_axi_arbiter;
  import ysyx_22050598_axi_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [2:0]  if_size;
  logic [63:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [2:0]  ls_size;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wstrb;
  logic [63:0] ls_rdata;
  logic        ls_done;
  logic        ls_err;

  int errors = 0;
  int checks = 0;
  bit tb_ptr_ls = 1'b1;

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];

  ysyx_22050598_axi_arbiter_if #(.AW(64), .DW(64)) axi ();

  ysyx_22050598_axi_arbiter #(.AW(64), .DW(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_size  (if_size),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_err   (if_err),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_size  (ls_size),
    .ls_wdata (ls_wdata),
    .ls_wstrb (ls_wstrb),
    .ls_rdata (ls_rdata),
    .ls_done  (ls_done),
    .ls_err   (ls_err),
    .m_axi    (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Which unit the bench expects to win when both request together.
  function automatic bit model_ls_first();
`ifdef YSYX_22050598_AXI_ARB_RR_EN
    return tb_ptr_ls;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push(input bit is_ls, input bit we, input logic [63:0] addr, input logic [2:0] size,
                      input logic [63:0] data, input logic [7:0] strb, input logic [1:0] resp);
    exp_t e;
    e.is_ls = is_ls; e.we = we; e.addr = addr; e.size = size;
    e.data = data; e.strb = strb; e.resp = resp;
    sb.push_back(e);
    tb_ptr_ls = !is_ls;
  endtask

  // Play the slave for the transaction at the head of the queue until a done pulse appears.
  task automatic serve(input int ar_dly, input int aw_dly, input int w_dly, input int rb_dly,
                       output int cyc, output int first_v);
    exp_t e;
    bit ar_f = 0, aw_f = 0, w_f = 0, r_f = 0, b_f = 0;
    bit ar_ok = 0, aw_ok = 0, w_ok = 0, rb_ok = 0;
    bit xchan = 0, stray = 0, unstable = 0, done_seen = 0;
    int arw = 0, aww = 0, ww = 0, rbw = 0;
    int ar_hi = 0, aw_hi = 0, w_hi = 0;
    cyc = 0; first_v = 0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb[0];
    while (!done_seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ar_f) begin ar_ok = 1; axi.arready = 1'b0; end
      if (aw_f) begin aw_ok = 1; axi.awready = 1'b0; end
      if (w_f)  begin w_ok  = 1; axi.wready  = 1'b0; end
      if (r_f)  begin rb_ok = 1; axi.rvalid  = 1'b0; end
      if (b_f)  begin rb_ok = 1; axi.bvalid  = 1'b0; end
      if (if_done || ls_done) begin
        done_seen = 1;
        void'(sb.pop_front());
        chk("done_unit", {63'd0, ls_done}, {63'd0, e.is_ls});
        chk("single_done", {63'd0, if_done & ls_done}, 64'd0);
        chk("err", {63'd0, e.is_ls ? ls_err : if_err}, {63'd0, e.resp != 2'b00});
        if (!e.we) chk("rdata", e.is_ls ? ls_rdata : if_rdata, e.data);
        if (e.is_ls) ls_req = 1'b0; else if_req = 1'b0;
      end else begin
        if (first_v == 0 && (axi.arvalid || axi.awvalid || axi.wvalid)) begin
          first_v = cyc;
          if (e.we) begin
            chk("aw_fields", {axi.awid, axi.awlen, axi.awburst, axi.awsize, axi.wlast},
                {4'd1, 8'd0, 2'b01, e.size, 1'b1});
            chk("aw_w_together", {63'd0, axi.awvalid & axi.wvalid}, 64'd1);
          end else begin
            chk("ar_fields", {axi.arid, axi.arlen, axi.arburst, axi.arsize},
                {e.is_ls ? 4'd1 : 4'd0, 8'd0, 2'b01, e.size});
          end
        end
        if (e.we) begin
          xchan |= axi.arvalid | axi.rready;
          stray |= (aw_ok & axi.awvalid) | (w_ok & axi.wvalid) | (!(aw_ok & w_ok) & axi.bready);
          if (axi.awvalid && !aw_ok) begin
            aw_hi++;
            unstable |= (axi.awaddr !== e.addr);
            if (aww >= aw_dly) axi.awready = 1'b1; else aww++;
          end
          if (axi.wvalid && !w_ok) begin
            w_hi++;
            unstable |= (axi.wdata !== e.data) | (axi.wstrb !== e.strb);
            if (ww >= w_dly) axi.wready = 1'b1; else ww++;
          end
          if (aw_ok && w_ok && !rb_ok) begin
            if (rbw >= rb_dly) begin
              axi.bvalid = 1'b1; axi.bresp = e.resp; axi.bid = 4'd1;
            end else rbw++;
          end
        end else begin
          xchan |= axi.awvalid | axi.wvalid | axi.bready;
          stray |= (ar_ok & axi.arvalid) | (!ar_ok & axi.rready);
          if (axi.arvalid && !ar_ok) begin
            ar_hi++;
            unstable |= (axi.araddr !== e.addr);
            if (arw >= ar_dly) axi.arready = 1'b1; else arw++;
          end
          if (ar_ok && !rb_ok) begin
            if (rbw >= rb_dly) begin
              axi.rvalid = 1'b1; axi.rdata = e.data; axi.rresp = e.resp;
              axi.rid = e.is_ls ? 4'd1 : 4'd0; axi.rlast = 1'b1;
            end else rbw++;
          end
        end
      end
      ar_f = axi.arvalid & axi.arready;
      aw_f = axi.awvalid & axi.awready;
      w_f  = axi.wvalid  & axi.wready;
      r_f  = axi.rvalid  & axi.rready;
      b_f  = axi.bvalid  & axi.bready;
    end
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b0; axi.bvalid = 1'b0;
    chk("done_within_budget", {63'd0, done_seen}, 64'd1);
    chk("other_channel_idle", {63'd0, xchan}, 64'd0);
    chk("valid_drop_rules", {63'd0, stray}, 64'd0);
    chk("payload_stable", {63'd0, unstable}, 64'd0);
    if (e.we) begin
      chk("awvalid_cycles", aw_hi, aw_dly + 1);
      chk("wvalid_cycles", w_hi, w_dly + 1);
    end else begin
      chk("arvalid_cycles", ar_hi, ar_dly + 1);
    end
  endtask

  initial begin
    int cyc, fv, dn;
    bit ls_first;
    rst = 1'b0;
    if_req = 1'b0; if_addr = 64'd0; if_size = 3'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 64'd0; ls_size = 3'd0;
    ls_wdata = 64'd0; ls_wstrb = 8'd0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'd0;
    axi.rvalid = 1'b0; axi.rdata = 64'd0; axi.rresp = 2'b00; axi.rid = 4'd0; axi.rlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valids", {59'd0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 64'd0);
    chk("reset_done_err", {60'd0, if_done, ls_done, if_err, ls_err}, 64'd0);
    chk("reset_if_rdata", if_rdata, 64'd0);
    chk("reset_ls_rdata", ls_rdata, 64'd0);
    rst = 1'b1;
    tb_ptr_ls = 1'b1;
    @(negedge clk);

    // IF read, zero-wait slave
    if_req = 1'b1; if_addr = 64'h8000_0000; if_size = 3'd2;
    push(1'b0, 1'b0, 64'h8000_0000, 3'd2, 64'h13, 8'h00, 2'b00);
    serve(0, 0, 0, 0, cyc, fv);
    chk("if_read_latency", cyc, 3);
    chk("if_read_first_ar", fv, 1);
    @(negedge clk);

    // LS write with AWREADY late by 2 cycles, WREADY immediate
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1000; ls_size = 3'd2;
    ls_wdata = 64'hDEAD_BEEF; ls_wstrb = 8'h0F;
    push(1'b1, 1'b1, 64'h8000_1000, 3'd2, 64'hDEAD_BEEF, 8'h0F, 2'b00);
    serve(0, 2, 0, 0, cyc, fv);
    chk("ls_write_latency", cyc, 5);
    chk("if_rdata_held", if_rdata, 64'h13);
    @(negedge clk);

    // LS write with W late and AW immediate, delayed B carrying DECERR
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_2008; ls_size = 3'd3;
    ls_wdata = 64'h0123_4567_89AB_CDEF; ls_wstrb = 8'hFF;
    push(1'b1, 1'b1, 64'h8000_2008, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b11);
    serve(0, 0, 3, 2, cyc, fv);
    ls_we = 1'b0;
    @(negedge clk);

    // Two rounds of simultaneous IF and LS reads
    for (int pair = 0; pair < 2; pair++) begin
      if_req = 1'b1; if_addr = 64'h8000_0100 + 64'(pair * 16); if_size = 3'd2;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_3000 + 64'(pair * 16); ls_size = 3'd3;
      ls_first = model_ls_first();
      if (ls_first) begin
        push(1'b1, 1'b0, ls_addr, 3'd3, 64'hA000 + 64'(pair), 8'h00, 2'b00);
        push(1'b0, 1'b0, if_addr, 3'd2, 64'hB000 + 64'(pair), 8'h00, 2'b00);
      end else begin
        push(1'b0, 1'b0, if_addr, 3'd2, 64'hB000 + 64'(pair), 8'h00, 2'b00);
        push(1'b1, 1'b0, ls_addr, 3'd3, 64'hA000 + 64'(pair), 8'h00, 2'b00);
      end
      serve(0, 0, 0, 1, cyc, fv);
      chk("pair_first_ar", fv, 1);
      serve(1, 0, 0, 0, cyc, fv);
      chk("pair_bubble", fv, 2);
      @(negedge clk);
    end

    // LS read answered with SLVERR
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_4000; ls_size = 3'd3;
    push(1'b1, 1'b0, 64'h8000_4000, 3'd3, 64'h55AA_55AA, 8'h00, 2'b10);
    serve(1, 0, 0, 2, cyc, fv);
    @(negedge clk);

    // ARREADY held low for 10 cycles
    if_req = 1'b1; if_addr = 64'h8000_0200; if_size = 3'd2;
    push(1'b0, 1'b0, 64'h8000_0200, 3'd2, 64'h0000_0297, 8'h00, 2'b00);
    serve(10, 0, 0, 0, cyc, fv);
    @(negedge clk);

    // Reset asserted while waiting in R
    if_req = 1'b1; if_addr = 64'h8000_0040; if_size = 3'd2;
    @(negedge clk);
    chk("rst_pre_arvalid", {63'd0, axi.arvalid}, 64'd1);
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    chk("rst_pre_rready", {63'd0, axi.rready}, 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_drop", {62'd0, axi.rready, axi.arvalid}, 64'd0);
    if_req = 1'b0;
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      dn += int'(if_done) + int'(ls_done);
    end
    rst = 1'b1;
    tb_ptr_ls = 1'b1;
    repeat (3) begin
      @(negedge clk);
      dn += int'(if_done) + int'(ls_done) + int'(axi.arvalid);
    end
    chk("rst_no_done", dn, 0);

    // Fresh IF read after the reset
    if_req = 1'b1; if_addr = 64'h8000_0080; if_size = 3'd2;
    push(1'b0, 1'b0, 64'h8000_0080, 3'd2, 64'h0000_0513, 8'h00, 2'b00);
    serve(0, 0, 0, 0, cyc, fv);
    chk("post_rst_latency", cyc, 3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050598_axi_arbiter.md
# ysyx_22050598_axi_arbiter

Shares the CPU's single AXI4 master port between the instruction-fetch (IF) and load/store (LS) units inside ysyx_22050598_cpu. Each unit issues simple single-beat requests. The arbiter grants one requester at a time, runs exactly one AXI transaction (LEN=0) to completion, then returns data and a completion pulse. Only one transaction is outstanding at any time.

## Interface
Parameters:
- AW, default 64: address width.
- DW, default 64: data width. WSTRB width is DW/8.

Ports:
- clk  in  1  core clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-low reset (same net as the slave's ARESETN).
- if_req  in  1  IF read request, level. Held until if_done.
- if_addr  in  AW  IF address. Stable while if_req is high.
- if_size  in  3  AXI size code for the IF request.
- if_rdata  out  DW  IF read data. Valid when if_done is high.
- if_done  out  1  one-cycle completion pulse for IF.
- if_err  out  1  RRESP was not OKAY. Valid with if_done.
- ls_req  in  1  LS request, level. Held until ls_done.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  AW  LS address.
- ls_size  in  3  AXI size code for the LS request.
- ls_wdata  in  DW  LS write data.
- ls_wstrb  in  DW/8  LS write byte strobes.
- ls_rdata  out  DW  LS read data. Valid when ls_done is high.
- ls_done  out  1  one-cycle completion pulse for LS.
- ls_err  out  1  RRESP or BRESP was not OKAY. Valid with ls_done.
- M_AXI_AW*/W*/B*/AR*/R*  mixed  AXI4 master channels, same signal set as the cpu top-level M_AXI ports.

## Operation
- FSM states: IDLE, AR, R, AWW, B.
- IDLE:
  - Requests are sampled only in IDLE, and only when no done pulse is high in that cycle.
  - The grant is registered. Address, size and data of the winner are latched.
  - Next state is AR for a read, AWW for an LS write.
- Arbitration without RR_EN: fixed priority, LS wins over IF.
- AR: ARVALID=1 with the latched ARADDR and ARSIZE. ARID is 0 for IF and 1 for LS. On ARREADY, go to R.
- R: RREADY=1. On RVALID:
  - register RDATA into the granted unit's rdata.
  - set err = (RRESP != 0).
  - go to IDLE and pulse the granted unit's done in that IDLE cycle.
- AWW:
  - AWVALID and WVALID rise together. Each drops independently after its own handshake; AW and W may complete in either order or in the same cycle.
  - Go to B once both handshakes are done.
- B: BREADY=1. On BVALID: set ls_err = (BRESP != 0), go to IDLE, pulse ls_done.
- Constant AXI fields:
  - LEN=0, BURST=INCR (2'b01), WLAST=1.
  - CACHE=0, PROT=0, QOS=0.
  - AWID=1.
- RLAST is ignored, because every read is single-beat.
- The rdata registers hold their value until the next completion for that unit.

## Timing
- Reset values (async assert): state IDLE; every VALID, READY, done and err output is 0; rdata is 0; the round-robin pointer points to LS.
- Read latency: req seen at cycle 0 → ARVALID at cycle 1 → done 1 cycle after the R handshake. Minimum is 3 cycles with a zero-wait slave.
- Write latency: AWVALID and WVALID at cycle 1 → BREADY from the cycle after both handshakes → ls_done 1 cycle after the B handshake.
- VALIDs never depend combinationally on READYs. A VALID, once raised, stays high with stable payload until its handshake.
- A requester deasserts req during its done cycle. The arbiter ignores req during any done cycle, which gives a guaranteed 1-cycle bubble and prevents a double grant.
- Request arriving while the arbiter is busy: it waits, no loss.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, all VALIDs drop, and the transaction is abandoned with no done pulse.

## Configuration
- YSYX_22050598_AXI_ARB_RR_EN
  - Defined: round-robin arbitration. When both units request in IDLE, the unit not granted last wins; the pointer updates on every grant.
  - Undefined: fixed LS-over-IF priority, and the pointer logic is absent.

## Structure
- ysyx_22050598_defines.v holds:
  - FSM state encodings.
  - AXI constants: BURST_INCR, RESP_OKAY, ID_IF=0, ID_LS=1.
  - the RR_EN macro.
- Sub-module ysyx_22050598_arb_sel:
  - inputs: two requests and the pointer.
  - outputs: one-hot grant.
  - round-robin or fixed priority under the macro.

## Test plan
- IF read alone, addr 0x8000_0000, zero-wait slave returning 0x0013 → ARID=0, ARADDR=0x8000_0000, if_rdata=0x13, if_done at cycle 3, if_err=0.
- LS write to 0x8000_1000, wdata 0xDEAD_BEEF, wstrb 0x0F, with AWREADY delayed 2 cycles and WREADY immediate → WVALID drops after 1 cycle, AWVALID stays high until AWREADY, single ls_done, ls_err=0.
- IF and LS requesting reads in the same cycle:
  - without RR_EN: LS granted first, then IF, 1-cycle bubble between them.
  - with RR_EN: back-to-back pairs alternate IF/LS.
- Slave returns RRESP=2'b10 on an LS read → ls_done with ls_err=1, and ls_rdata takes RDATA.
- rst driven low while in R with RVALID not yet seen → RREADY=0 at once, no done pulse, after release the FSM is in IDLE and serves a new IF request normally.
- ARREADY held low for 10 cycles → ARVALID and ARADDR stable for all 10 cycles, no other channel becomes active.
